// File: rtl/dma_ahb_master.sv
// AHB-Lite master engine for the DMA: latches a granted stream's setup, runs one
// burst (or a run of singles) against the bus, and moves data to/from that stream's FIFO.
module dma_ahb_master #(
    parameter int numb_ch = 1,
    parameter int addr_w  = 32,
    // Stream select width (dma_log2 of the channel count, never below one bit).
    localparam int sel_w  = (numb_ch > 1) ? $clog2(numb_ch) : 1
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic              i_master_en,
    input  logic [sel_w-1:0]  i_stream_sel,
    output logic              o_master_ready,
    input  logic [addr_w-1:0] i_addr  [numb_ch-1:0],
    input  logic [1:0]        i_size  [numb_ch-1:0],
    input  logic [1:0]        i_burst [numb_ch-1:0],
    input  logic              i_inc   [numb_ch-1:0],
    input  logic              i_write [numb_ch-1:0],
    input  logic [31:0]       i_wdata,
    output logic              o_fifo_rd,
    output logic              o_fifo_wr,
    output logic [31:0]       o_rdata,
    output logic [addr_w-1:0] o_haddr,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic              o_hwrite,
    output logic [31:0]       o_hwdata,
    input  logic [31:0]       i_hrdata,
    input  logic              i_hready,
    input  logic              i_hresp,
    output logic              o_done,
    output logic              o_error,
    output logic [sel_w-1:0]  o_done_stream,
    output logic [addr_w-1:0] o_done_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_ERR
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t            r_state;
    logic [sel_w-1:0]  r_sel;
    logic [1:0]        r_size;
    logic              r_inc;
    logic              r_write;
    logic              r_single;
    logic [4:0]        r_cnt;
    logic              r_dph;
    logic [addr_w-1:0] r_dph_addr;
    logic              r_ready;
    logic [addr_w-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic [2:0]        r_hsize;
    logic [2:0]        r_hburst;
    logic              r_hwrite;
    logic [31:0]       r_hwdata;
    logic [31:0]       r_rdata;
    logic              r_fifo_wr;
    logic              r_done;
    logic              r_error;
    logic [sel_w-1:0]  r_done_stream;
    logic [addr_w-1:0] r_done_addr;

    logic [numb_ch-1:0] w_hit;
    logic [addr_w-1:0]  w_g_addr;
    logic [1:0]         w_g_size_raw;
    logic [1:0]         w_g_size;
    logic [1:0]         w_g_burst;
    logic               w_g_inc;
    logic               w_g_write;
    logic [4:0]         w_g_beats;
    logic [10:0]        w_g_bytes;
    logic [10:0]        w_g_end;
    logic               w_g_single;
    logic [2:0]         w_g_hburst;
    logic               w_grant;
    logic               w_accept;
    logic               w_err1;
    logic [addr_w-1:0]  w_step;

    generate
        for (genvar gi = 0; gi < numb_ch; gi++) begin : g_hit
            assign w_hit[gi] = (i_stream_sel == sel_w'(gi));
        end
    endgenerate

    always_comb begin
        w_g_addr     = '0;
        w_g_size_raw = 2'd0;
        w_g_burst    = 2'd0;
        w_g_inc      = 1'b0;
        w_g_write    = 1'b0;
        for (int i = 0; i < numb_ch; i++) begin
            if (w_hit[i]) begin
                w_g_addr     = i_addr[i];
                w_g_size_raw = i_size[i];
                w_g_burst    = i_burst[i];
                w_g_inc      = i_inc[i];
                w_g_write    = i_write[i];
            end
        end
    end

    always_comb begin
        case (w_g_burst)
            2'd0:    w_g_beats = 5'd1;
            2'd1:    w_g_beats = 5'd4;
            2'd2:    w_g_beats = 5'd8;
            default: w_g_beats = 5'd16;
        endcase
    end

    // Bursts that would run past a 1 KB boundary (or never increment) fall back to singles.
    assign w_g_size   = (w_g_size_raw == 2'd3) ? 2'd2 : w_g_size_raw;
    assign w_g_bytes  = {6'b0, w_g_beats} << w_g_size;
    assign w_g_end    = {1'b0, w_g_addr[9:0]} + w_g_bytes;
    assign w_g_single = !w_g_inc || (w_g_end > 11'd1024) || (w_g_burst == 2'd0);
    assign w_g_hburst = w_g_single          ? 3'd0 :
                        (w_g_burst == 2'd1) ? 3'd3 :
                        (w_g_burst == 2'd2) ? 3'd5 : 3'd7;

    assign w_grant  = (r_state == S_IDLE) && r_ready && i_master_en;
    assign w_accept = (r_state == S_ADDR) && r_htrans[1] && i_hready;
    assign w_err1   = ((r_state == S_ADDR) || (r_state == S_LAST)) && r_dph && i_hresp && !i_hready;
    assign w_step   = {{(addr_w-1){1'b0}}, 1'b1} << r_size;

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_size        <= 2'd0;
            r_inc         <= 1'b0;
            r_write       <= 1'b0;
            r_single      <= 1'b0;
            r_cnt         <= 5'd0;
            r_dph         <= 1'b0;
            r_dph_addr    <= '0;
            r_ready       <= 1'b1;
            r_haddr       <= '0;
            r_htrans      <= HT_IDLE;
            r_hsize       <= 3'd0;
            r_hburst      <= 3'd0;
            r_hwrite      <= 1'b0;
            r_hwdata      <= 32'd0;
            r_rdata       <= 32'd0;
            r_fifo_wr     <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_done_stream <= '0;
            r_done_addr   <= '0;
        end else begin
            r_fifo_wr <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_sel    <= i_stream_sel;
                        r_size   <= w_g_size;
                        r_inc    <= w_g_inc;
                        r_write  <= w_g_write;
                        r_single <= w_g_single;
                        r_cnt    <= w_g_beats;
                        r_haddr  <= w_g_addr;
                        r_htrans <= HT_NONSEQ;
                        r_hsize  <= {1'b0, w_g_size};
                        r_hburst <= w_g_hburst;
                        r_hwrite <= w_g_write;
                        r_ready  <= 1'b0;
                        r_state  <= S_ADDR;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_ADDR, S_LAST: begin
                    if (w_err1) begin
                        // Cancel the rest of the burst; the faulting beat stays in r_dph_addr.
                        r_htrans <= HT_IDLE;
                        r_cnt    <= 5'd0;
                        r_state  <= S_ERR;
                    end else if (i_hready) begin
                        if (r_dph && !r_write) begin
                            r_fifo_wr <= 1'b1;
                            r_rdata   <= i_hrdata;
                        end
                        if (r_state == S_LAST) begin
                            r_dph         <= 1'b0;
                            r_done        <= 1'b1;
                            r_done_addr   <= r_haddr;
                            r_done_stream <= r_sel;
                            r_state       <= S_IDLE;
                        end else if (w_accept) begin
                            r_dph      <= 1'b1;
                            r_dph_addr <= r_haddr;
                            r_cnt      <= r_cnt - 5'd1;
                            if (r_inc) begin
                                r_haddr <= r_haddr + w_step;
                            end
                            if (r_write) begin
                                r_hwdata <= i_wdata;
                            end
                            if (r_cnt == 5'd1) begin
                                r_htrans <= HT_IDLE;
                                r_state  <= S_LAST;
                            end else begin
                                r_htrans <= r_single ? HT_NONSEQ : HT_SEQ;
                            end
                        end
                    end
                end
                S_ERR: begin
                    if (i_hready) begin
                        r_dph         <= 1'b0;
                        r_done        <= 1'b1;
                        r_error       <= 1'b1;
                        r_done_addr   <= r_dph_addr;
                        r_done_stream <= r_sel;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // HTRANS drops to IDLE within the first error cycle, before the register catches up.
    assign o_htrans       = w_err1 ? HT_IDLE : r_htrans;
    assign o_fifo_rd      = w_accept && r_write;
    assign o_master_ready = r_ready;
    assign o_haddr        = r_haddr;
    assign o_hsize        = r_hsize;
    assign o_hburst       = r_hburst;
    assign o_hwrite       = r_hwrite;
    assign o_hwdata       = r_hwdata;
    assign o_rdata        = r_rdata;
    assign o_fifo_wr      = r_fifo_wr;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_done_stream  = r_done_stream;
    assign o_done_addr    = r_done_addr;

endmodule

// File: tb/tb_dma_ahb_master.sv
// Directed bench for dma_ahb_master: a table of transactions run against a small
// AHB slave model, plus hand-written reset sequences.
module tb_dma_ahb_master;
    localparam int NCH = 4;
    localparam int AW  = 32;

    logic          clk;
    logic          nreset;
    logic          master_en;
    logic [1:0]    stream_sel;
    logic          master_ready;
    logic [AW-1:0] addr_a  [NCH-1:0];
    logic [1:0]    size_a  [NCH-1:0];
    logic [1:0]    burst_a [NCH-1:0];
    logic          inc_a   [NCH-1:0];
    logic          write_a [NCH-1:0];
    logic [31:0]   wdata;
    logic          fifo_rd;
    logic          fifo_wr;
    logic [31:0]   rdata;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic          hwrite;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hready;
    logic          hresp;
    logic          done;
    logic          err;
    logic [1:0]    done_stream;
    logic [AW-1:0] done_addr;

    int n_vec = 0;
    int n_bad = 0;

    dma_ahb_master #(.numb_ch(NCH), .addr_w(AW)) dut (
        .i_clk(clk), .i_nreset(nreset),
        .i_master_en(master_en), .i_stream_sel(stream_sel), .o_master_ready(master_ready),
        .i_addr(addr_a), .i_size(size_a), .i_burst(burst_a), .i_inc(inc_a), .i_write(write_a),
        .i_wdata(wdata), .o_fifo_rd(fifo_rd), .o_fifo_wr(fifo_wr), .o_rdata(rdata),
        .o_haddr(haddr), .o_htrans(htrans), .o_hsize(hsize), .o_hburst(hburst),
        .o_hwrite(hwrite), .o_hwdata(hwdata), .i_hrdata(hrdata), .i_hready(hready),
        .i_hresp(hresp), .o_done(done), .o_error(err), .o_done_stream(done_stream),
        .o_done_addr(done_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [1:0]  burst;
        logic        inc;
        logic        write;
        int          waits;
        int          err_beat;
        logic [2:0]  exp_hburst;
        logic [2:0]  exp_hsize;
        int          exp_beats;
        logic [31:0] exp_step;
        logic        exp_seq;
        logic [31:0] exp_done_addr;
        int          exp_xfers;
        logic        exp_error;
    } vec_t;

    vec_t vt [8];

    function automatic vec_t mk(input logic [1:0] sel, input logic [31:0] addr, input logic [1:0] size,
                                input logic [1:0] burst, input logic inc, input logic write,
                                input int waits, input int err_beat, input logic [2:0] eb,
                                input logic [2:0] es, input int nb, input logic [31:0] step,
                                input logic seq, input logic [31:0] da, input int nx, input logic ee);
        vec_t v;
        v.sel = sel; v.addr = addr; v.size = size; v.burst = burst; v.inc = inc; v.write = write;
        v.waits = waits; v.err_beat = err_beat; v.exp_hburst = eb; v.exp_hsize = es;
        v.exp_beats = nb; v.exp_step = step; v.exp_seq = seq; v.exp_done_addr = da;
        v.exp_xfers = nx; v.exp_error = ee;
        return v;
    endfunction

    function automatic logic [31:0] wpat(input int vi, input int k);
        return 32'hA000_0000 + 32'(vi << 16) + 32'(k * 32'h0101);
    endfunction

    function automatic logic [31:0] rpat(input int vi, input int k);
        return 32'hC0DE_0000 + 32'(vi << 8) + 32'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic program_streams(input vec_t v);
        for (int s = 0; s < NCH; s++) begin
            addr_a[s]  = 32'hDEAD_0000 + 32'(s * 32'h100);
            size_a[s]  = 2'd0;
            burst_a[s] = 2'd3;
            inc_a[s]   = 1'b1;
            write_a[s] = ~v.write;
        end
        addr_a[v.sel]  = v.addr;
        size_a[v.sel]  = v.size;
        burst_a[v.sel] = v.burst;
        inc_a[v.sel]   = v.inc;
        write_a[v.sel] = v.write;
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        int   acc, pops, pushes, cyc, dbeat, wleft, errc;
        bit   dph, done_seen;
        logic [31:0] ea;
        v = vt[vi];
        cyc = 0;
        while (master_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("ready_before_grant", 32'(master_ready), 32'd1);
        program_streams(v);
        stream_sel = v.sel;
        master_en  = 1'b1;
        acc = 0; pops = 0; pushes = 0; dbeat = 0; wleft = 0; errc = 0;
        dph = 1'b0; done_seen = 1'b0; cyc = 0;
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            // Post-grant changes to the selection and stream registers must be ignored.
            stream_sel    = v.sel ^ 2'd1;
            addr_a[v.sel] = 32'hBAD0_0000;
            wdata  = wpat(vi, pops);
            hresp  = 1'b0;
            hready = 1'b1;
            hrdata = 32'h0;
            if (dph) begin
                if (dbeat + 1 == v.err_beat) begin
                    hresp  = 1'b1;
                    hready = (errc == 1);
                end else if (wleft > 0) begin
                    hready = 1'b0;
                end else begin
                    hrdata = rpat(vi, dbeat);
                end
            end
            #1;
            if (cyc == 1) begin
                chk("first_nonseq", 32'(htrans), 32'd2);
                chk("ready_low", 32'(master_ready), 32'd0);
            end
            if (dph && hresp && !hready) chk("err_htrans_idle", 32'(htrans), 32'd0);
            if (dph && v.write && (dbeat + 1 != v.err_beat)) chk("hwdata_hold", hwdata, wpat(vi, dbeat));
            if (htrans[1] && hready) begin
                ea = v.addr + 32'(acc) * v.exp_step;
                chk("haddr", haddr, ea);
                chk("htrans", 32'(htrans), (acc == 0 || !v.exp_seq) ? 32'd2 : 32'd3);
                chk("hburst", 32'(hburst), 32'(v.exp_hburst));
                chk("hsize", 32'(hsize), 32'(v.exp_hsize));
                chk("hwrite", 32'(hwrite), 32'(v.write));
                chk("fifo_rd", 32'(fifo_rd), 32'(v.write));
            end else begin
                chk("fifo_rd_idle", 32'(fifo_rd), 32'd0);
            end
            if (fifo_rd) pops++;
            if (fifo_wr) begin
                chk("rdata", rdata, rpat(vi, pushes));
                pushes++;
            end
            if (done) begin
                done_seen = 1'b1;
                chk("done_addr", done_addr, v.exp_done_addr);
                chk("done_stream", 32'(done_stream), 32'(v.sel));
                chk("error", 32'(err), 32'(v.exp_error));
                chk("beats", 32'(acc), 32'(v.exp_beats));
                chk("pops", 32'(pops), v.write ? 32'(v.exp_xfers) : 32'd0);
                chk("pushes", 32'(pushes), v.write ? 32'd0 : 32'(v.exp_xfers));
                master_en = 1'b0;
            end
            if (dph) begin
                if (dbeat + 1 == v.err_beat) begin
                    if (errc == 1) dph = 1'b0;
                    else errc = 1;
                end else if (!hready) begin
                    wleft--;
                end else begin
                    dph = 1'b0;
                end
            end
            if (htrans[1] && hready) begin
                dph   = 1'b1;
                dbeat = acc;
                wleft = v.waits;
                errc  = 0;
                acc++;
            end
        end
        master_en = 1'b0;
        if (!done_seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout vec %0d: got no o_done required o_done within 300 cycles", vi);
        end
        @(negedge clk);
        #1;
        chk("ready_restored", 32'(master_ready), 32'd1);
        chk("done_pulse", 32'(done), 32'd0);
        $display("vec %0d: stream %0d addr 0x%08h beats %0d pops %0d pushes %0d done_addr 0x%08h err %0b",
                 vi, v.sel, v.addr, acc, pops, pushes, done_addr, err);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(master_ready), 32'd1);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
        chk({tag, "_haddr"}, haddr, 32'd0);
        chk({tag, "_hburst"}, 32'(hburst), 32'd0);
        chk({tag, "_hwdata"}, hwdata, 32'd0);
        chk({tag, "_pulses"}, {28'd0, fifo_rd, fifo_wr, done, err}, 32'd0);
        chk({tag, "_done_addr"}, done_addr, 32'd0);
    endtask

    initial begin
        // sel addr size burst inc write waits errb | hburst hsize beats step seq done_addr xfers err
        vt[0] = mk(2'd2, 32'h2000_0000, 2'd2, 2'd1, 1'b1, 1'b0, 0, 0, 3'd3, 3'd2,  4, 32'd4, 1'b1, 32'h2000_0010,  4, 1'b0);
        vt[1] = mk(2'd1, 32'h3000_0102, 2'd1, 2'd0, 1'b1, 1'b1, 2, 0, 3'd0, 3'd1,  1, 32'd2, 1'b0, 32'h3000_0104,  1, 1'b0);
        vt[2] = mk(2'd0, 32'h0000_03F0, 2'd2, 2'd3, 1'b1, 1'b0, 0, 0, 3'd0, 3'd2, 16, 32'd4, 1'b0, 32'h0000_0430, 16, 1'b0);
        vt[3] = mk(2'd3, 32'h4000_0007, 2'd0, 2'd2, 1'b0, 1'b1, 1, 0, 3'd0, 3'd0,  8, 32'd0, 1'b0, 32'h4000_0007,  8, 1'b0);
        vt[4] = mk(2'd1, 32'h1000_0040, 2'd2, 2'd2, 1'b1, 1'b0, 0, 3, 3'd5, 3'd2,  3, 32'd4, 1'b1, 32'h1000_0048,  2, 1'b1);
        vt[5] = mk(2'd0, 32'h0000_03F0, 2'd1, 2'd2, 1'b1, 1'b1, 1, 0, 3'd5, 3'd1,  8, 32'd2, 1'b1, 32'h0000_0400,  8, 1'b0);
        vt[6] = mk(2'd2, 32'hFFFF_FFF8, 2'd3, 2'd1, 1'b1, 1'b0, 0, 0, 3'd0, 3'd2,  4, 32'd4, 1'b0, 32'h0000_0008,  4, 1'b0);
        vt[7] = mk(2'd3, 32'h5000_0000, 2'd2, 2'd1, 1'b1, 1'b1, 0, 0, 3'd3, 3'd2,  4, 32'd4, 1'b1, 32'h5000_0010,  4, 1'b0);

        nreset = 1'b0; master_en = 1'b0; stream_sel = 2'd0;
        wdata = 32'd0; hrdata = 32'd0; hready = 1'b1; hresp = 1'b0;
        program_streams(vt[0]);
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        nreset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset in the middle of a long read burst.
        program_streams(vt[2]);
        addr_a[0] = 32'h6000_0000;
        stream_sel = 2'd0;
        master_en = 1'b1;
        hready = 1'b1; hresp = 1'b0;
        repeat (6) @(negedge clk);
        master_en = 1'b0;
        #1;
        chk("midburst_active", 32'(master_ready), 32'd0);
        nreset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        #1;
        chk_reset_outputs("midrst_hold");
        nreset = 1'b1;
        $display("reset mid-burst: outputs at reset values");

        run_vec(7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_ahb_master.md
Name: dma_ahb_master

Overview:
- Bus-side transfer engine that consumes the stream arbiter's grant (master_en / stream_sel) and returns the master_ready handshake to it.
- On each grant it latches the selected stream's address, size, burst and direction.
- It then issues one AHB-Lite burst, or a sequence of single transfers, and moves data between the bus and that stream's FIFO.
- When the transaction is done it reports completion and the next address back to the stream registers.

Parameters:
numb_ch, 1, number of DMA streams; select width is dma_log2(numb_ch)
addr_w, 32, AHB address width

Ports:
i_clk  in  1  clock
i_nreset  in  1  async active-low reset
i_master_en  in  1  grant from arbiter
i_stream_sel  in  dma_log2(numb_ch)  granted stream index
o_master_ready  out  1  engine idle, may accept a grant / arbiter may swap
i_addr[numb_ch-1:0]  in  addr_w  per-stream current bus address
i_size[numb_ch-1:0]  in  2  0 byte, 1 hword, 2 word
i_burst[numb_ch-1:0]  in  2  0 single, 1 inc4, 2 inc8, 3 inc16
i_inc[numb_ch-1:0]  in  1  address increment enable
i_write[numb_ch-1:0]  in  1  1 = memory write (FIFO to bus), 0 = read (bus to FIFO)
i_wdata  in  32  head of the selected stream's FIFO
o_fifo_rd  out  1  pop pulse, selected FIFO
o_fifo_wr  out  1  push pulse, selected FIFO
o_rdata  out  32  push data
o_haddr  out  addr_w  AHB HADDR
o_htrans  out  2  AHB HTRANS
o_hsize  out  3  AHB HSIZE
o_hburst  out  3  AHB HBURST
o_hwrite  out  1  AHB HWRITE
o_hwdata  out  32  AHB HWDATA
i_hrdata  in  32  AHB HRDATA
i_hready  in  1  AHB HREADY
i_hresp  in  1  AHB HRESP
o_done  out  1  transaction complete pulse
o_error  out  1  bus error pulse, coincident with o_done
o_done_stream  out  dma_log2(numb_ch)  stream of o_done
o_done_addr  out  addr_w  address following the last accepted beat

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - State IDLE; o_master_ready=1.
  - o_htrans=IDLE(0); o_haddr, o_hsize, o_hburst, o_hwrite, o_hwdata, o_rdata, o_done_* = 0.
  - All pulses (o_fifo_rd, o_fifo_wr, o_done, o_error) = 0.
- Grant: sampled when state IDLE & o_master_ready & i_master_en.
  - Latch sel, addr, size, burst, inc, write; go to ADDR.
  - o_master_ready drops the cycle after the grant.
  - First NONSEQ appears one cycle after the grant.
- Beat count: 1, 4, 8 or 16 for burst codes 0-3.
  - Counter is 5 bits; it loads the beat count at grant and decrements on each accepted address phase.
- HBURST and beat type:
  - HBURST is SINGLE=0, INCR4=3, INCR8=5, INCR16=7.
  - Forced to SINGLE, with every beat NONSEQ, when i_inc=0 or when the burst would cross a 1 KB boundary. The crossing test is addr[9:0] + beats<<size > 1024.
  - Otherwise beat 1 is NONSEQ and later beats are SEQ.
- HSIZE = {1'b0, size}; sizes 3 and above are treated as word.
- Address stepping:
  - An address phase is accepted when i_hready=1 and o_htrans is NONSEQ or SEQ.
  - On acceptance, haddr advances by 1<<size if inc=1, else it holds.
  - Arithmetic is modulo 2^addr_w.
- Pipelining: the data phase of beat n overlaps the address phase of beat n+1. No IDLE/BUSY is inserted inside a burst.
- Write direction:
  - o_fifo_rd pulses in the cycle an address phase is accepted.
  - o_hwdata is registered from i_wdata in that cycle and held until the data phase completes (i_hready=1).
- Read direction: on data-phase completion (i_hready=1), o_fifo_wr pulses for one cycle and o_rdata = i_hrdata in the same cycle.
- States:
  - ADDR: drives beats. After the last address phase is accepted, go to LAST (htrans=IDLE).
  - LAST: on final data-phase completion, pulse o_done, set o_done_addr, go to IDLE. o_master_ready=1 the following cycle.
- Error: i_hresp=1 with i_hready=0 in a data phase (first error cycle).
  - The engine drives htrans=IDLE that cycle and cancels the remaining beats; the counter is cleared.
  - The pending address phase is not retried, and a write pop already issued for the cancelled beat is not counted.
  - On the second error cycle (i_hready=1), o_done=1 and o_error=1 pulse, o_done_addr = address of the faulting beat, go to IDLE.
- Wait states: while i_hready=0, every AHB output and the beat counter hold.
- Arbiter interaction:
  - i_master_en and i_stream_sel changes after the grant are ignored until IDLE.
  - i_master_en high while o_master_ready=0 is not a new grant.

Test Plan:
- Word INCR4 read: stream 2, addr 0x2000_0000, no wait states -> NONSEQ + 3 SEQ at 0x..00/04/08/0C, HBURST=3, 4 o_fifo_wr pulses with matching HRDATA, o_done with done_addr 0x2000_0010, ready restored.
- Hword single write with 2 wait states per beat -> HWDATA held through the waits, exactly 1 o_fifo_rd, HSIZE=1, done_addr = base+2.
- Word INCR16 at 0x0000_03F0 -> 1 KB crossing: 16 NONSEQ SINGLE beats at 0x3F0..0x42C, done_addr 0x430.
- i_inc=0 byte INCR8 -> 8 NONSEQ SINGLE beats all at the same address, HSIZE=0, done_addr unchanged.
- ERROR response on beat 3 of INCR8 read -> htrans IDLE in the first error cycle, no further beats, o_done+o_error on the second cycle, done_addr = beat-3 address, 2 pushes only.
- i_nreset asserted mid-burst, then released, then a new grant -> outputs at reset values immediately and a clean NONSEQ start for the new grant.
